a51_decryption: RTL

- Serial-keyed A5/1 stream decryptor: the receive-side counterpart of the team's A5/1 encryption block.
- Loads a 64-bit session key bit-serially, optionally runs a warm-up, then XORs ciphertext bytes with the keystream to produce plaintext bytes.
- Ciphertext enters and plaintext leaves through valid/ready handshakes, one byte at a time.
- Sits between the link receive path and the byte consumer.

---
 rtl/a51_decryption.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/a51_decryption.sv
// A5/1 stream decryptor: loads a 64-bit session key serially, optionally warms up,
// then XORs each accepted ciphertext byte with eight keystream bits (bit 0 first).
module a51_decryption #(
    parameter int WARMUP_CYCLES = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_start,
    input  logic       hkey,
    input  logic       hkey_valid,
    input  logic [7:0] inbyte,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] outbyte,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       key,
    output logic       keyed
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WARM,
        S_WAIT,
        S_DEC,
        S_OUT
    } state_t;

    // Member order makes the packed struct line up with the key: bits [18:0] are R1,
    // [40:19] are R2 and [63:41] are R3, so a key bit index addresses the struct directly.
    typedef struct packed {
        logic [22:0] r3;
        logic [21:0] r2;
        logic [18:0] r1;
    } lfsr_t;

    localparam logic [9:0] WARM_LAST = 10'((WARMUP_CYCLES > 0) ? (WARMUP_CYCLES - 1) : 0);

    function automatic lfsr_t lfsr_step(input lfsr_t s);
        lfsr_t n;
        logic  maj;
        n   = s;
        maj = (s.r1[8] & s.r2[10]) | (s.r1[8] & s.r3[10]) | (s.r2[10] & s.r3[10]);
        if (s.r1[8] == maj)
            n.r1 = {s.r1[17:0], s.r1[13] ^ s.r1[16] ^ s.r1[17] ^ s.r1[18]};
        if (s.r2[10] == maj)
            n.r2 = {s.r2[20:0], s.r2[20] ^ s.r2[21]};
        if (s.r3[10] == maj)
            n.r3 = {s.r3[21:0], s.r3[7] ^ s.r3[20] ^ s.r3[21] ^ s.r3[22]};
        return n;
    endfunction

    state_t     state;
    lfsr_t      lfsr;
    lfsr_t      lfsr_next;
    logic       ks_next;
    logic [5:0] load_cnt;
    logic [9:0] warm_cnt;
    logic [2:0] bit_cnt;
    logic [7:0] cipher;
    logic [7:0] plain;

    // The keystream bit is taken from the register contents after the step.
    assign lfsr_next = lfsr_step(lfsr);
    assign ks_next   = lfsr_next.r1[18] ^ lfsr_next.r2[21] ^ lfsr_next.r3[22];

    // NOTE: every register here is state, so all assignments are non-blocking;
    // reads within the block therefore see the values from before this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            lfsr      <= '0;
            load_cnt  <= '0;
            warm_cnt  <= '0;
            bit_cnt   <= '0;
            cipher    <= '0;
            plain     <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            outbyte   <= '0;
            key       <= 1'b0;
            keyed     <= 1'b0;
        end else if (key_start) begin
            // A new key overrides everything, including a handshake on this edge.
            state     <= S_LOAD;
            lfsr      <= '0;
            load_cnt  <= '0;
            warm_cnt  <= '0;
            bit_cnt   <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            key       <= 1'b0;
            keyed     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    state <= S_IDLE;
                end

                S_LOAD: begin
                    if (hkey_valid) begin
                        lfsr[load_cnt] <= hkey;
                        load_cnt       <= load_cnt + 6'd1;
                        if (load_cnt == 6'd63) begin
                            if (WARMUP_CYCLES > 0) begin
                                state <= S_WARM;
                            end else begin
                                state    <= S_WAIT;
                                in_ready <= 1'b1;
                                keyed    <= 1'b1;
                            end
                        end
                    end
                end

                S_WARM: begin
                    lfsr <= lfsr_next;
                    key  <= ks_next;
                    if (warm_cnt == WARM_LAST) begin
                        state    <= S_WAIT;
                        in_ready <= 1'b1;
                        keyed    <= 1'b1;
                    end else begin
                        warm_cnt <= warm_cnt + 10'd1;
                    end
                end

                S_WAIT: begin
                    if (in_valid) begin
                        cipher   <= inbyte;
                        bit_cnt  <= '0;
                        in_ready <= 1'b0;
                        state    <= S_DEC;
                    end
                end

                S_DEC: begin
                    // Ciphertext shifts out LSB first; plaintext shifts in from the top
                    // so bit i lands at position i after eight steps.
                    lfsr    <= lfsr_next;
                    key     <= ks_next;
                    cipher  <= {1'b0, cipher[7:1]};
                    plain   <= {cipher[0] ^ ks_next, plain[7:1]};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        outbyte   <= {cipher[0] ^ ks_next, plain[7:1]};
                        out_valid <= 1'b1;
                        state     <= S_OUT;
                    end
                end

                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_WAIT;
                    end
                end

                default: begin
                    state     <= S_IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    keyed     <= 1'b0;
                end
            endcase
        end
    end

endmodule
